part_74s225: RTL and testbench

PART_74S225 -- requirements
Module: part_74S225

---
 rtl/part_74s225.sv | 68 ++++++
 tb/tb_part_74s225.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/part_74s225.sv
// 16x5 first-word-fall-through FIFO with occupancy count, ready/half-full flags
// and a tri-stateable head-of-queue output.
module part_74s225 (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D,
    input  logic       SI,
    input  logic       SO,
    input  logic       OE,
    output logic [4:0] Q,
    output logic       IR,
    output logic       OR,
    output logic       HF,
    output logic [4:0] CNT
);

    logic [4:0] mem_q [16];
    logic [3:0] wr_ptr_q, wr_ptr_d;
    logic [3:0] rd_ptr_q, rd_ptr_d;
    logic [4:0] cnt_q, cnt_d;
    logic       wr_en, rd_en;
    logic [4:0] head;

    // Flags come only from the registered count, never from SI/SO.
    assign IR  = (cnt_q != 5'd16);
    assign OR  = (cnt_q != 5'd0);
    assign HF  = (cnt_q >= 5'd8);
    assign CNT = cnt_q;

    assign wr_en = SI && IR;
    assign rd_en = SO && OR;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 4'd1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 4'd1;
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + 5'd1;
            2'b01:   cnt_d = cnt_q - 5'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 4'd0;
            rd_ptr_q <= 4'd0;
            cnt_q    <= 5'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is never cleared; stale words become unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wr_ptr_q] <= D;
        end
    end

    assign head = OR ? mem_q[rd_ptr_q] : 5'd0;
    assign Q    = OE ? head : 5'bzzzzz;

endmodule

// File: tb/tb_part_74s225.sv
// Scoreboard bench for part_74s225: a queue-based FIFO model predicts status
// and read data; a negedge monitor pops and compares.
module tb_part_74s225;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D;
    logic       SI, SO, OE;
    wire  [4:0] q_w;
    logic       IR, OR, HF;
    logic [4:0] CNT;

    for (genvar gi = 0; gi < 5; gi++) begin : g_pu
        pullup (q_w[gi]);
    end

    part_74s225 dut (
        .clk(clk), .reset(reset), .D(D), .SI(SI), .SO(SO), .OE(OE),
        .Q(q_w), .IR(IR), .OR(OR), .HF(HF), .CNT(CNT)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] cnt;
        logic       ir;
        logic       orf;
        logic       hf;
        logic [4:0] q;
    } stat_t;

    logic [4:0] mdl[$];
    logic [4:0] exp_q[$];
    stat_t      stat_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    bit         mon_en = 1'b0;

    function automatic void chk(string name, logic [4:0] act, logic [4:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b required %b", name, act, req);
    endfunction

    function automatic stat_t model_status();
        stat_t s;
        int n = mdl.size();
        s.cnt = 5'(n);
        s.ir  = (n < 16);
        s.orf = (n > 0);
        s.hf  = (n >= 8);
        s.q   = (n > 0) ? mdl[0] : 5'd0;
        return s;
    endfunction

    // One clock of stimulus: record the state the DUT should now show,
    // then apply inputs and advance the model by the edge they will cause.
    task automatic cycle(input logic si, input logic so, input logic [4:0] d);
        bit wr, rd;
        @(posedge clk);
        #2;
        stat_q.push_back(model_status());
        SI = si; SO = so; D = d;
        wr = si && (mdl.size() < 16);
        rd = so && (mdl.size() > 0);
        if (rd) exp_q.push_back(mdl.pop_front());
        if (wr) mdl.push_back(d);
        $display("txn si=%0b so=%0b d=%h -> wr=%0b rd=%0b occ=%0d", si, so, d, wr, rd, mdl.size());
    endtask

    initial begin : monitor
        stat_t s;
        forever begin
            @(negedge clk);
            if (mon_en && !reset) begin
                if (stat_q.size() > 0) begin
                    s = stat_q.pop_front();
                    chk("cnt", CNT, s.cnt);
                    chk("ir", {4'd0, IR}, {4'd0, s.ir});
                    chk("or", {4'd0, OR}, {4'd0, s.orf});
                    chk("hf", {4'd0, HF}, {4'd0, s.hf});
                    chk("q", q_w, s.q);
                end
                if (SO && OR) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL read_unexpected: got %h required no read", q_w);
                    end else begin
                        chk("read", q_w, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int p_si, p_so;
        reset = 1'b1; SI = 0; SO = 0; D = 0; OE = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        mon_en = 1'b1;

        // Basic FWFT ordering
        cycle(1, 0, 5'h0A); cycle(1, 0, 5'h15); cycle(1, 0, 5'h1F);
        cycle(0, 0, 0);
        repeat (3) cycle(0, 1, 0);
        cycle(0, 0, 0);

        // Fill to 16, ignored 17th write, drain in order
        for (int i = 0; i < 16; i++) cycle(1, 0, 5'(i));
        cycle(1, 0, 5'h1E);
        for (int i = 0; i < 16; i++) cycle(0, 1, 0);
        cycle(0, 0, 0);

        // Full with simultaneous SI/SO: read only
        for (int i = 0; i < 16; i++) cycle(1, 0, 5'(i + 3));
        cycle(1, 1, 5'h11);
        cycle(0, 0, 0);
        for (int i = 0; i < 15; i++) cycle(0, 1, 0);
        cycle(0, 0, 0);

        // Empty with simultaneous SI/SO: write only
        cycle(1, 1, 5'h07);
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        // Steady occupancy 4 through pointer wraps
        for (int i = 0; i < 4; i++) cycle(1, 0, 5'(i + 20));
        for (int i = 0; i < 20; i++) cycle(1, 1, 5'($urandom_range(0, 31)));
        for (int i = 0; i < 4; i++) cycle(0, 1, 0);
        cycle(0, 0, 0);

        // Randomized phases biased toward filling then draining
        for (int ph = 0; ph < 6; ph++) begin
            p_si = (ph % 2 == 0) ? 80 : 25;
            p_so = (ph % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 60; i++)
                cycle($urandom_range(0, 99) < p_si, $urandom_range(0, 99) < p_so,
                      5'($urandom_range(0, 31)));
        end
        while (mdl.size() != 9) begin
            if (mdl.size() < 9) cycle(1, 0, 5'($urandom_range(0, 31)));
            else cycle(0, 1, 0);
        end
        cycle(0, 0, 0);
        @(negedge clk);

        // Asynchronous reset between edges with occupancy 9
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_cnt", CNT, 5'd0);
        chk("rst_or", {4'd0, OR}, 5'd0);
        chk("rst_ir", {4'd0, IR}, 5'd1);
        chk("rst_hf", {4'd0, HF}, 5'd0);
        chk("rst_q", q_w, 5'd0);
        OE = 1'b0;
        #1;
        chk("oe_off_q", q_w, 5'b11111);
        OE = 1'b1;
        SI = 1'b1; SO = 1'b1; D = 5'h1F;
        @(posedge clk);
        #2;
        chk("rst_ignore_si", CNT, 5'd0);
        SI = 0; SO = 0;
        mdl.delete();
        exp_q.delete();
        stat_q.delete();
        reset = 1'b0;
        $display("txn reset pulse -> occ=0");

        // Post-reset: stale words must not reappear
        cycle(1, 0, 5'h05); cycle(1, 0, 5'h06);
        cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (exp_q.size() == 0 && stat_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d/%0d pending required 0/0", exp_q.size(), stat_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
